data_sram_responder: RTL

- Behavioural-RTL responder for the CPU data-SRAM request/response interface: the memory end that pipeline load/store stages talk to.
- Accepts requests via req/addr_ok and returns in-order responses via data_ok/rdata after fixed LATENCY.
- rdata is always the full aligned word; the requester does byte/half extraction and sign extension from addr[1:0].
- Used in the SoC sim top and as the stage-level test target.

---
 rtl/data_sram_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_sram_responder.sv
// Behavioural data-SRAM responder: accepts load/store requests, performs the memory
// access at accept time and returns in-order responses a fixed LATENCY later.
module data_sram_responder #(
   parameter int MEM_WORDS       = 1024,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   input  logic        stall_inject,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic        err_misalign
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   // timer only ever holds values up to LATENCY-1
   localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [31:0] BAD_WORD = 32'hDEADBEEF;

   typedef struct packed {
      logic          vld;
      logic [TW-1:0] tmr;
      logic [31:0]   data;
   } entry_t;

   logic [31:0] mem [MEM_WORDS] = '{default: '0};
   entry_t      q [MAX_OUTSTANDING];
   logic [PW-1:0] head, tail, nxt_head;
   logic [CW-1:0] count;

   logic          accept, misalign, pop, due_q, due_new, data_ok_n;
   logic [IW-1:0] idx;
   logic [31:0]   word, resp_data, rdata_n;
   logic          unused_addr;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   assign unused_addr = ^data_sram_addr[31:IW+2];

   assign data_sram_addr_ok = ~stall_inject & (count < CW'(MAX_OUTSTANDING));
   assign accept            = data_sram_req & data_sram_addr_ok;
   assign idx               = data_sram_addr[IW+1:2];
   assign word              = mem[idx];

   always_comb begin
      misalign = 1'b0;
      case (data_sram_size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = data_sram_addr[0];
         default: misalign = |data_sram_addr[1:0];
      endcase
   end

   assign resp_data = data_sram_wr ? 32'h0 : (misalign ? BAD_WORD : word);

   // The head leaves the queue at the end of its data_ok cycle, so it still
   // occupies a slot (and counts against addr_ok) while it is being answered.
   assign pop      = data_sram_data_ok;
   assign nxt_head = pop ? inc(head) : head;
   assign due_q    = q[nxt_head].vld && (q[nxt_head].tmr == TW'(1));
   assign due_new  = (LATENCY == 1) && accept;
   assign data_ok_n = due_q | due_new;
   assign rdata_n   = due_new ? resp_data : q[nxt_head].data;

   always_ff @(posedge clk) begin
      if (resetn && accept && data_sram_wr && !misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) mem[idx][i*8 +: 8] <= data_sram_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         head              <= '0;
         tail              <= '0;
         count             <= '0;
         data_sram_data_ok <= 1'b0;
         data_sram_rdata   <= '0;
         err_misalign      <= 1'b0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) q[i] <= '0;
      end else begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q[i].vld && (q[i].tmr != '0)) q[i].tmr <= q[i].tmr - TW'(1);
         end
         if (pop) begin
            q[head].vld <= 1'b0;
            head        <= inc(head);
         end
         if (accept) begin
            q[tail] <= '{vld: 1'b1, tmr: TW'(LATENCY - 1), data: resp_data};
            tail    <= inc(tail);
         end
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         data_sram_data_ok <= data_ok_n;
         if (data_ok_n) data_sram_rdata <= rdata_n;
         if (accept && misalign) err_misalign <= 1'b1;
      end
   end

endmodule
